// File: rtl/axis_pkt_tx.sv
// rtl/axis_pkt_tx.sv - AXI-Stream packet transmitter driven by length/mode/seed commands
module axis_pkt_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [1:0]            cmd_mode,
    input  logic [DATA_WIDTH-1:0] cmd_seed,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  pkt_count
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                state;
    state_t                state_nxt;

    logic [LEN_WIDTH-1:0]  len_q;
    logic [1:0]            mode_q;
    logic [DATA_WIDTH-1:0] seed_q;
    logic [LEN_WIDTH-1:0]  beat_cnt;

    logic                  last_beat;
    logic                  beat_hs;
    logic                  accept;
    logic [DATA_WIDTH-1:0] pattern;

    assign last_beat = (beat_cnt == len_q);
    assign beat_hs   = m_tvalid & m_tready;
    assign accept    = cmd_valid & cmd_ready;

    // Beat data is a pure function of the latched command and the beat index,
    // so it stays stable for as long as the beat counter is held by a stall.
    always_comb begin
        pattern = seed_q;
        case (mode_q)
            2'd0:    pattern = seed_q + DATA_WIDTH'(beat_cnt);
            2'd2:    pattern = beat_cnt[0] ? ~seed_q : seed_q;
            default: pattern = seed_q;
        endcase
    end

    // State register
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a new command on the last handshake keeps us in SEND
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = SEND;
            SEND: if (beat_hs && last_beat && !accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: valid/last/data come from registered state only;
    // cmd_ready in SEND is the one path that looks at m_tready
    always_comb begin
        cmd_ready = 1'b0;
        m_tvalid  = 1'b0;
        m_tlast   = 1'b0;
        busy      = 1'b0;
        m_tdata   = '0;
        case (state)
            IDLE: begin
                cmd_ready = wrst_n;
            end
            SEND: begin
                m_tvalid  = 1'b1;
                m_tlast   = last_beat;
                busy      = 1'b1;
                m_tdata   = pattern;
                cmd_ready = m_tready & last_beat;
            end
            default: ;
        endcase
    end

    // Command latch and beat counter
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            len_q    <= '0;
            mode_q   <= '0;
            seed_q   <= '0;
            beat_cnt <= '0;
        end else if (accept) begin
            len_q    <= cmd_len;
            mode_q   <= cmd_mode;
            seed_q   <= cmd_seed;
            beat_cnt <= '0;
        end else if (beat_hs && !last_beat) begin
            beat_cnt <= beat_cnt + LEN_WIDTH'(1);
        end
    end

    // Completed-packet counter, wraps naturally
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            pkt_count <= '0;
        end else if (beat_hs && last_beat) begin
            pkt_count <= pkt_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_axis_pkt_tx.sv
// tb/tb_axis_pkt_tx.sv - directed table-driven bench for axis_pkt_tx
module tb_axis_pkt_tx;

    logic        wclk;
    logic        wrst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_len;
    logic [1:0]  cmd_mode;
    logic [7:0]  cmd_seed;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        busy;
    logic [15:0] pkt_count;

    axis_pkt_tx #(
        .DATA_WIDTH(8),
        .LEN_WIDTH (8),
        .CNT_WIDTH (16)
    ) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .cmd_mode  (cmd_mode),
        .cmd_seed  (cmd_seed),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tlast   (m_tlast),
        .busy      (busy),
        .pkt_count (pkt_count)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    typedef struct packed {
        logic [7:0]      len;
        logic [1:0]      mode;
        logic [7:0]      seed;
        logic [0:3][7:0] exp;
    } vec_t;

    int   n_pass;
    int   n_total;
    int   exp_pkts;
    vec_t vecs[6];
    vec_t v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, want);
    endtask

    function automatic logic [7:0] model(input logic [1:0] m, input logic [7:0] s, input int k);
        logic [7:0] kb;
        kb = 8'(k);
        case (m)
            2'd0:    return 8'(s + kb);
            2'd2:    return kb[0] ? ~s : s;
            default: return s;
        endcase
    endfunction

    // One packet with m_tready held high; beats beyond the table come from the model.
    task automatic run_pkt(input vec_t pv);
        logic [7:0] want;
        @(negedge wclk);
        cmd_valid = 1'b1;
        cmd_len   = pv.len;
        cmd_mode  = pv.mode;
        cmd_seed  = pv.seed;
        m_tready  = 1'b1;
        #1;
        check("cmd_ready_idle", cmd_ready, 1);
        @(posedge wclk);
        for (int k = 0; k <= int'(pv.len); k++) begin
            @(negedge wclk);
            cmd_valid = 1'b0;
            cmd_len   = ~pv.len;
            cmd_seed  = ~pv.seed;
            cmd_mode  = ~pv.mode;
            #1;
            want = (k < 4) ? pv.exp[k] : model(pv.mode, pv.seed, k);
            check("beat_valid", m_tvalid, 1);
            check("beat_data", m_tdata, want);
            check("beat_last", m_tlast, (k == int'(pv.len)) ? 1 : 0);
            @(posedge wclk);
        end
        exp_pkts++;
        @(negedge wclk);
        #1;
        check("end_valid", m_tvalid, 0);
        check("end_busy", busy, 0);
        check("end_pkt_count", pkt_count, exp_pkts);
    endtask

    initial begin
        logic [7:0] b2b_exp [6];
        logic [7:0] b2b_seed [3];
        logic [7:0] pd;
        logic       pl;
        logic       prev_stall;
        logic       acc;
        int         hs;
        int         idx;
        int         beats;

        n_pass    = 0;
        n_total   = 0;
        exp_pkts  = 0;
        wrst_n    = 1'b0;
        cmd_valid = 1'b0;
        cmd_len   = 8'd0;
        cmd_mode  = 2'd0;
        cmd_seed  = 8'd0;
        m_tready  = 1'b0;

        vecs[0] = '{len: 8'd3, mode: 2'd0, seed: 8'hFE, exp: {8'hFE, 8'hFF, 8'h00, 8'h01}};
        vecs[1] = '{len: 8'd0, mode: 2'd2, seed: 8'hA5, exp: {8'hA5, 8'h00, 8'h00, 8'h00}};
        vecs[2] = '{len: 8'd3, mode: 2'd2, seed: 8'hA5, exp: {8'hA5, 8'h5A, 8'hA5, 8'h5A}};
        vecs[3] = '{len: 8'd2, mode: 2'd3, seed: 8'h77, exp: {8'h77, 8'h77, 8'h77, 8'h00}};
        vecs[4] = '{len: 8'd1, mode: 2'd1, seed: 8'h00, exp: {8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[5] = '{len: 8'd3, mode: 2'd0, seed: 8'h10, exp: {8'h10, 8'h11, 8'h12, 8'h13}};

        // Reset state
        #12;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tlast", m_tlast, 0);
        check("rst_busy", busy, 0);
        check("rst_tdata", m_tdata, 0);
        check("rst_pkt_count", pkt_count, 0);
        @(negedge wclk);
        wrst_n = 1'b1;

        // Table of single packets
        for (int i = 0; i < 6; i++) run_pkt(vecs[i]);

        // Stall: len=4 constant 0x3C with ready low stretches
        @(negedge wclk);
        cmd_valid = 1'b1;
        cmd_len   = 8'd4;
        cmd_mode  = 2'd1;
        cmd_seed  = 8'h3C;
        m_tready  = 1'b0;
        @(posedge wclk);
        hs = 0;
        prev_stall = 1'b0;
        pd = 8'h00;
        pl = 1'b0;
        for (int c = 0; c < 200 && hs < 5; c++) begin
            @(negedge wclk);
            cmd_valid = 1'b0;
            cmd_seed  = 8'h99;
            if ((c % 12) < 5) m_tready = 1'b0;
            else if ((c % 12) == 11) m_tready = 1'b1;
            else m_tready = 1'($urandom_range(0, 1));
            #1;
            check("stall_valid", m_tvalid, 1);
            check("stall_data", m_tdata, 8'h3C);
            check("stall_last", m_tlast, (hs == 4) ? 1 : 0);
            if (prev_stall) begin
                check("stall_hold_data", m_tdata, pd);
                check("stall_hold_last", m_tlast, pl);
            end
            pd = m_tdata;
            pl = m_tlast;
            prev_stall = ~m_tready;
            if (m_tready) hs++;
            @(posedge wclk);
        end
        check("stall_handshakes", hs, 5);
        exp_pkts++;
        @(negedge wclk);
        m_tready = 1'b1;
        #1;
        check("stall_end_valid", m_tvalid, 0);
        check("stall_pkt_count", pkt_count, exp_pkts);

        // Back-to-back: three queued len=1 commands
        b2b_seed = '{8'h20, 8'h40, 8'h60};
        b2b_exp  = '{8'h20, 8'h21, 8'h40, 8'h41, 8'h60, 8'h61};
        idx   = 0;
        beats = 0;
        for (int c = 0; c < 30 && beats < 6; c++) begin
            @(negedge wclk);
            cmd_valid = (idx < 3);
            cmd_len   = 8'd1;
            cmd_mode  = 2'd0;
            if (idx < 3) cmd_seed = b2b_seed[idx];
            m_tready  = 1'b1;
            #1;
            if (beats > 0) check("b2b_no_gap", m_tvalid, 1);
            if (m_tvalid) begin
                check("b2b_data", m_tdata, b2b_exp[beats]);
                check("b2b_last", m_tlast, beats % 2);
                check("b2b_cmd_ready", cmd_ready, beats % 2);
                beats++;
            end else begin
                check("b2b_ready_idle", cmd_ready, 1);
            end
            acc = cmd_valid & cmd_ready;
            @(posedge wclk);
            if (acc) idx++;
        end
        check("b2b_beats", beats, 6);
        check("b2b_accepted", idx, 3);
        exp_pkts += 3;
        @(negedge wclk);
        cmd_valid = 1'b0;
        #1;
        check("b2b_end_valid", m_tvalid, 0);
        check("b2b_pkt_count", pkt_count, exp_pkts);

        // Maximum-length packets (256 beats)
        v = '{len: 8'd255, mode: 2'd0, seed: 8'h05, exp: {8'h05, 8'h06, 8'h07, 8'h08}};
        run_pkt(v);
        v = '{len: 8'd255, mode: 2'd2, seed: 8'hC3, exp: {8'hC3, 8'h3C, 8'hC3, 8'h3C}};
        run_pkt(v);

        // Reset mid-packet at beat 2 of len=7
        @(negedge wclk);
        cmd_valid = 1'b1;
        cmd_len   = 8'd7;
        cmd_mode  = 2'd0;
        cmd_seed  = 8'h00;
        m_tready  = 1'b1;
        @(posedge wclk);
        @(negedge wclk);
        cmd_valid = 1'b0;
        @(posedge wclk);
        @(posedge wclk);
        @(negedge wclk);
        #1;
        check("mid_beat2_data", m_tdata, 8'h02);
        check("mid_pkt_count", pkt_count, exp_pkts);
        wrst_n = 1'b0;
        #1;
        check("arst_tvalid", m_tvalid, 0);
        check("arst_tlast", m_tlast, 0);
        check("arst_busy", busy, 0);
        check("arst_cmd_ready", cmd_ready, 0);
        check("arst_pkt_count", pkt_count, 0);
        exp_pkts = 0;
        @(negedge wclk);
        wrst_n = 1'b1;
        #1;
        check("post_rst_cmd_ready", cmd_ready, 1);
        check("post_rst_tvalid", m_tvalid, 0);
        v = '{len: 8'd1, mode: 2'd0, seed: 8'h80, exp: {8'h80, 8'h81, 8'h00, 8'h00}};
        run_pkt(v);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
